// File: rtl/sync_fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO subsystem.
package sync_fifo_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefDepth = 16;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $unsigned($clog2(depth)) + 32'd1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_updn_counter.sv
// Up/down counter with synchronous clear; also exposes its next value so callers
// can register derived state in step with the count.
module fifo_updn_counter #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         clr_,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!clr_) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = up ? cnt_q + W'(1) : cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count     = cnt_q;
    assign count_nxt = cnt_d;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: register-array storage, modulo pointers, occupancy counter
// and registered status flags that track the count on the same edge.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                    clk,
    input  logic                    rst_,
    input  logic                    clr_,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam fifo_status_t StatusRst = '{
        full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
        overflow: 1'b0, underflow: 1'b0
    };

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    fifo_status_t     status_q, status_d;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             wa, ra;

    // A flush cycle accepts nothing.
    assign wa = clr_ && wr_en && !status_q.full;
    assign ra = clr_ && rd_en && !status_q.empty;

    fifo_updn_counter #(
        .W(CW)
    ) u_occ_cnt (
        .clk       (clk),
        .rst_      (rst_),
        .clr_      (clr_),
        .en        (wa ^ ra),
        .up        (wa),
        .count     (cnt),
        .count_nxt (cnt_nxt)
    );

    always_comb begin
        wr_ptr_d   = wa ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = ra ? rd_ptr_q + PW'(1) : rd_ptr_q;
        rd_data_d  = ra ? mem[rd_ptr_q] : rd_data_q;
        rd_valid_d = ra;

        status_d.full         = (cnt_nxt == CW'(DEPTH));
        status_d.empty        = (cnt_nxt == '0);
        status_d.almost_full  = (cnt_nxt >= CW'(AF_LEVEL));
        status_d.almost_empty = (cnt_nxt <= CW'(AE_LEVEL));
        status_d.overflow     = status_q.overflow || (wr_en && status_q.full);
        status_d.underflow    = status_q.underflow || (rd_en && status_q.empty);

        if (!clr_) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rd_data_d  = '0;
            rd_valid_d = 1'b0;
            status_d   = StatusRst;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            status_q   <= StatusRst;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            status_q   <= status_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign count        = cnt;
    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = status_q.overflow;
    assign underflow    = status_q.underflow;

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Synchronous single-clock FIFO with the storage array, read/write pointers, an occupancy counter, and status flags. The block is the buffering stage of the Sync FIFO subsystem. It accepts push/pop requests from producer and consumer logic and returns registered read data. Occupancy tracking uses a small up/down counter sub-module, driven by the controller's accepted-write and accepted-read strobes.

## Interface
- WIDTH, 16, data word width in bits
- DEPTH, 16, number of entries; power of two, ≥ 4
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- clk  input  1  clock, all state on rising edge
- rst_  input  1  reset, asynchronous, active-low
- clr_  input  1  synchronous flush, active-low
- wr_en  input  1  push request
- wr_data  input  WIDTH  push data
- rd_en  input  1  pop request
- rd_data  output  WIDTH  registered pop data
- rd_valid  output  1  one-cycle pulse: rd_data holds the word popped in the previous cycle
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty  output  1 each  status flags, registered
- overflow, underflow  output  1 each  sticky error flags

## Operation
- Write accept (wa): wr_en && !full. Read accept (ra): rd_en && !empty. Flags are sampled from their registered values at the start of the cycle.
- On wa: mem[wr_ptr] ← wr_data; wr_ptr increments modulo DEPTH.
- On ra: rd_data ← mem[rd_ptr]; rd_ptr increments modulo DEPTH; rd_valid ← 1. Otherwise rd_valid ← 0 and rd_data holds its value.
- Occupancy count update:
  - wa && !ra: count + 1
  - ra && !wa: count − 1
  - both or neither: count holds
- Simultaneous push and pop:
  - When full: the write is rejected and overflow is set; the read proceeds, so count becomes DEPTH−1.
  - When empty: the read is rejected and underflow is set; the write proceeds, so count becomes 1.
  - Otherwise both proceed and count is unchanged.
- overflow sets on wr_en && full. underflow sets on rd_en && empty. Both stay set until rst_ or clr_.
- Flags are registered from next-count, so they are consistent with count in the same cycle:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ AF_LEVEL)
  - almost_empty = (count ≤ AE_LEVEL)
- Reset values (rst_ low), applied asynchronously:
  - count = 0, pointers = 0
  - empty = 1, almost_empty = 1
  - full = 0, almost_full = 0
  - rd_data = 0, rd_valid = 0
  - overflow = 0, underflow = 0
- Memory contents are not reset.
- clr_ low: same register values as reset, applied at the next edge. clr_ has priority over wr_en/rd_en in that cycle, and no accept occurs.
- Reset mid-operation: all queued data is discarded. The first push after reset deasserts empty one cycle later.

## Timing
- Write-to-read latency: a word pushed at edge N can be popped at edge N+1 (empty clears at N). The data appears on rd_data after edge N+1.
- Read latency: 1 cycle from ra to rd_data/rd_valid.
- Flags and count update on the same edge as the accepting access. There is no extra lag.
- Full throughput: one push and one pop per cycle, sustained, when 0 < count < DEPTH.
- Pointer wrap: DEPTH−1 → 0 with no bubble.

## Structure
- Package sync_fifo_pkg:
  - Default WIDTH/DEPTH constants
  - A function cnt_w(depth) = $clog2(depth)+1
  - typedef fifo_status_t, a packed struct {full, empty, almost_full, almost_empty, overflow, underflow}
- Sub-module fifo_updn_counter, parameterised width:
  - Inputs: rst_, clr_ (sync clear), en, up
  - Instantiated once for occupancy count, with en = wa ^ ra and up = wa
  - Pointers are plain modulo incrementers in the top module.
- Storage is an inferred register array inside sync_fifo_ctrl.

## Test plan
- Reset, then idle for 3 cycles → count=0, empty=1, almost_empty=1, full=0, rd_valid=0, rd_data=0.
- Push 16 words 0x0001..0x0010, then push 0xBEEF → full=1 after the 16th push; almost_full=1 at count=14; 0xBEEF is dropped; overflow=1; count stays 16.
- Pop 17 times from full → rd_data is 0x0001..0x0010 in order, each one cycle after the pop; the 17th pop gives underflow=1, no rd_valid, and empty=1.
- Simultaneous push+pop at count=5 for 40 cycles → count stays 5; data order is preserved across pointer wrap; rd_valid is high every cycle.
- Simultaneous push+pop when full → count=15, overflow=1. When empty → count=1, underflow=1, rd_valid=0.
- At count=9, assert clr_ for 1 cycle together with wr_en → count=0, empty=1, sticky flags cleared, and the write is not stored. Separately, assert rst_ low mid-burst → all outputs return to reset values immediately.
